// File: rtl/game_ctrl_fsm_if.sv
// Purpose: bundles the game sequencer's play-event inputs and status/strobe outputs.
// Ports (slave view, as seen by game_ctrl_fsm):
//   in : frame_tick, btn_start, brick_hit, ball_miss, max_score_reached
//   out: score_inc, score_clr, ball_reset, play_en, lives_left[1:0], win,
//        game_over, state[2:0]
interface game_ctrl_fsm_if;
    logic       frame_tick;
    logic       btn_start;
    logic       brick_hit;
    logic       ball_miss;
    logic       max_score_reached;
    logic       score_inc;
    logic       score_clr;
    logic       ball_reset;
    logic       play_en;
    logic [1:0] lives_left;
    logic       win;
    logic       game_over;
    logic [2:0] state;

    // Event source / status consumer side
    modport master (
        output frame_tick, btn_start, brick_hit, ball_miss, max_score_reached,
        input  score_inc, score_clr, ball_reset, play_en, lives_left, win,
               game_over, state
    );

    // Sequencer side
    modport slave (
        input  frame_tick, btn_start, brick_hit, ball_miss, max_score_reached,
        output score_inc, score_clr, ball_reset, play_en, lives_left, win,
               game_over, state
    );
endinterface

// File: rtl/game_ctrl_fsm.sv
// Purpose: top-level game sequencer. Converts play events into single-cycle
// score_inc/score_clr strobes for the score keeper and drives lives, serve and
// win/over status to the ball, paddle and overlay logic.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    game_ctrl_fsm_if.slave (events in, strobes/status out; all registered)
// Parameters:
//   LIVES       balls per game, 1..3
//   OVER_TICKS  frames WIN/OVER is held before returning to IDLE, 1..255
module game_ctrl_fsm #(
    parameter int unsigned LIVES      = 3,
    parameter int unsigned OVER_TICKS = 120
) (
    input  logic              clk,
    input  logic              reset,
    game_ctrl_fsm_if.slave    bus
);
    localparam int unsigned LIVES_W = 2;
    localparam int unsigned HOLD_W  = 8;
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(OVER_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_WIN   = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t              cur_state, nxt_state;
    logic [LIVES_W-1:0]  lives, nxt_lives;
    logic [HOLD_W-1:0]   hold_cnt, nxt_hold;
    logic                btn_start_d;
    logic                score_inc_r, nxt_inc;
    logic                score_clr_r, nxt_clr;
    logic                ball_reset_r, play_en_r, win_r, over_r;
    logic                start_edge;

    assign start_edge = bus.btn_start & ~btn_start_d;

    // State and registered outputs; button history resets high so a held
    // button never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state    <= ST_IDLE;
            lives        <= LIVES_INIT;
            hold_cnt     <= '0;
            btn_start_d  <= 1'b1;
            score_inc_r  <= 1'b0;
            score_clr_r  <= 1'b0;
            ball_reset_r <= 1'b1;
            play_en_r    <= 1'b0;
            win_r        <= 1'b0;
            over_r       <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            lives        <= nxt_lives;
            hold_cnt     <= nxt_hold;
            btn_start_d  <= bus.btn_start;
            score_inc_r  <= nxt_inc;
            score_clr_r  <= nxt_clr;
            ball_reset_r <= (nxt_state != ST_PLAY);
            play_en_r    <= (nxt_state == ST_PLAY);
            win_r        <= (nxt_state == ST_WIN);
            over_r       <= (nxt_state == ST_OVER);
        end
    end

    // Next-state and strobe decode
    always_comb begin
        nxt_state = cur_state;
        nxt_lives = lives;
        nxt_hold  = hold_cnt;
        nxt_inc   = 1'b0;
        nxt_clr   = 1'b0;
        unique case (cur_state)
            ST_IDLE: begin
                if (start_edge) begin
                    nxt_state = ST_SERVE;
                    nxt_clr   = 1'b1;
                    nxt_lives = LIVES_INIT;
                end
            end
            ST_SERVE: begin
                if (start_edge) begin
                    nxt_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Win beats miss beats hit; lower-priority events are dropped.
                if (bus.max_score_reached) begin
                    nxt_state = ST_WIN;
                    nxt_hold  = '0;
                end else if (bus.ball_miss) begin
                    if (lives <= LIVES_W'(1)) begin
                        nxt_lives = '0;
                        nxt_state = ST_OVER;
                        nxt_hold  = '0;
                    end else begin
                        nxt_lives = lives - LIVES_W'(1);
                        nxt_state = ST_SERVE;
                    end
                end else if (bus.brick_hit) begin
                    nxt_inc = 1'b1;
                end
            end
            ST_WIN, ST_OVER: begin
                if (bus.frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        nxt_state = ST_IDLE;
                        nxt_hold  = '0;
                    end else begin
                        nxt_hold = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    assign bus.score_inc  = score_inc_r;
    assign bus.score_clr  = score_clr_r;
    assign bus.ball_reset = ball_reset_r;
    assign bus.play_en    = play_en_r;
    assign bus.lives_left = lives;
    assign bus.win        = win_r;
    assign bus.game_over  = over_r;
    assign bus.state      = cur_state;
endmodule
